// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw board pins in, debounced levels and edge pulses out.
// All outputs are registered in sw_debounce; consumers sample them on the rising clk edge.
interface sw_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             any_change;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  any_change
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output any_change
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-bit slide-switch conditioner: 2-FF synchronizer, stability counter,
// registered clean level plus one-cycle rise/fall pulses.
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  bus
);
  localparam int            CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_any;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_done;

  // A bit commits when it has differed for STABLE_CYCLES consecutive edges.
  always_comb begin
    w_diff = r_sync2 ^ r_clean;
    w_done = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_done[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_any   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= bus.sw_raw;
      r_sync2 <= r_sync1;
      r_clean <= r_clean ^ w_done;
      r_rise  <= w_done & r_sync2;
      r_fall  <= w_done & ~r_sync2;
      r_any   <= |w_done;
      // Any return to the clean level, or a commit, restarts the count.
      for (int i = 0; i < WIDTH; i++) begin
        if (w_diff[i] && !w_done[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign bus.sw_clean   = r_clean;
  assign bus.sw_rise    = r_rise;
  assign bus.sw_fall    = r_fall;
  assign bus.any_change = r_any;
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Conditions the EGO1 slide-switch inputs before they reach the gate-level adder experiments. Those experiments read sw_pin[0..2] as A, B, Cin.
- Per bit: 2-FF synchronizer, then a stability counter. Outputs a clean level and one-cycle rise/fall pulses.
- Placement: board pins to sw_debounce to the combinational circuit under test. The clean bus connects to that circuit's switch inputs.

Parameters:
- WIDTH, 8, number of switch bits conditioned.
- STABLE_CYCLES, 1000000, consecutive cycles a synchronized input must differ from the clean level before the clean level flips. 10 ms at 100 MHz. Legal range 2 to 2^24. Benches use 4.

Ports:
- clk  input  1  system clock, 100 MHz board oscillator; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  asynchronous switch pins.
- sw_clean  output  WIDTH  debounced, registered switch levels.
- sw_rise  output  WIDTH  one-cycle pulse per bit on a clean 0->1 transition.
- sw_fall  output  WIDTH  one-cycle pulse per bit on a clean 1->0 transition.
- any_change  output  1  OR of sw_rise|sw_fall, registered in the same cycle as the pulses.

Behaviour:
- Reset: rst is sampled only on a clk rising edge. While rst=1, all of the following are 0:
  - sync1, sync2
  - all per-bit counters
  - sw_clean, sw_rise, sw_fall, any_change
- rst takes priority over every other update. Asserting rst mid-count discards the partial count.
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1. No logic between the two stages.
- Per bit i, each edge with rst=0:
  - If sync2[i] == sw_clean[i]: cnt[i] <= 0; no pulse.
  - Else if cnt[i] == STABLE_CYCLES-1: sw_clean[i] <= sync2[i]; cnt[i] <= 0; pulse sw_rise[i] or sw_fall[i] per the new level.
  - Else: cnt[i] <= cnt[i]+1; no pulse.
- Pulses: sw_rise, sw_fall and any_change are registered and default to 0 each cycle, so each is high for exactly one cycle.
- Counter width: clog2(STABLE_CYCLES). No wrap is possible, because the counter clears at STABLE_CYCLES-1.
- Latency: let E0 be the first edge that samples a new raw level, held stable thereafter.
  - sync2 updates at E1.
  - Counting starts at E2.
  - sw_clean and the pulse update at edge E(STABLE_CYCLES+1), i.e. STABLE_CYCLES+2 edges including E0.
- Glitch rejection: a change on sync2 that reverts before the count completes clears cnt. sw_clean is unchanged and no pulse is issued.
- Bounce during count: any return of sync2 to the clean level restarts the count from 0 on the next differing cycle.
- Bit independence: bits are fully independent. Several bits may pulse in the same cycle. any_change is 1 if any bit pulses.
- Post-reset: switches already high at reset release read 0 on sw_clean. Each such bit then produces a normal debounced rise after STABLE_CYCLES+2 edges. This is intended, and downstream logic must tolerate it.
- Constraint: no combinational path from sw_raw to any output.

Test Plan:
- Reset check, STABLE_CYCLES=4: rst=1 for 3 cycles with sw_raw=8'hFF -> all outputs 0 during reset.
  - After rst falls: sw_clean=8'hFF, sw_rise=8'hFF and any_change=1 for exactly one cycle, 6 edges after release.
- Clean step: sw_raw[0] 0->1 held -> sw_clean[0]=1 at edge E5, sw_rise[0] high only in that cycle, other bits 0.
  - Then sw_raw[0] 1->0 -> sw_fall[0] single pulse 6 edges later.
- Glitch: sw_raw[1] high for 3 cycles, then low -> sw_clean[1] stays 0, no pulses, cnt[1] returns to 0.
- Bounce: sw_raw[2] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> exactly one sw_rise[2].
  - That pulse lands 6 edges after the final 0->1 sample.
- Simultaneous: sw_raw 8'h00 -> 8'h07 in one cycle (A=B=Cin=1) -> sw_clean=8'h07, sw_rise=8'h07, any_change=1, all in the same cycle.
- Reset mid-count: sw_raw[3] rises, rst asserted on the 3rd counting cycle for 1 cycle -> no pulse.
  - After release, sw_rise[3] fires 6 edges later (counting restarted).
